// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: 2-entry skid buffer (main + skid) with valid/ready handshake.
// Optional ID_EX_BYPASS_EN: writeback bypass on capture and refresh of held operands.
module id_ex_stage #(
  parameter int CTRL_W = 12,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rs1_addr,
  input  logic [4:0]        in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [4:0]        in_rd_addr,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rs1_addr,
  output logic [4:0]        out_rs2_addr,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [4:0]        out_rd_addr,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state;
  entry_t main_q, skid_q;
  entry_t cap, main_r, skid_r;
  logic   acc, pop;

  assign acc       = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid & out_ready;

  // cap: incoming entry; main_r/skid_r: held entries after writeback refresh
  always_comb begin
    cap = '{pc: in_pc, rs1_addr: in_rs1_addr, rs2_addr: in_rs2_addr,
            rs1_data: in_rs1_data, rs2_data: in_rs2_data, rd_addr: in_rd_addr,
            imm: in_imm, ctrl: in_ctrl};
    main_r = main_q;
    skid_r = skid_q;
`ifdef ID_EX_BYPASS_EN
    if (wb_en && wb_addr != 5'd0) begin
      if (in_rs1_addr == wb_addr) cap.rs1_data = wb_data;
      if (in_rs2_addr == wb_addr) cap.rs2_data = wb_data;
      if (state != EMPTY) begin
        if (main_q.rs1_addr == wb_addr) main_r.rs1_data = wb_data;
        if (main_q.rs2_addr == wb_addr) main_r.rs2_data = wb_data;
      end
      if (state == TWO) begin
        if (skid_q.rs1_addr == wb_addr) skid_r.rs1_data = wb_data;
        if (skid_q.rs2_addr == wb_addr) skid_r.rs2_data = wb_data;
      end
    end
`endif
  end

`ifndef ID_EX_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data};
`endif

  // Flush overrides every transition; a popped entry simply leaves with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_q <= main_r;
      skid_q <= skid_r;
      if (flush) begin
        state    <= EMPTY;
        in_ready <= 1'b1;
      end else begin
        case (state)
          EMPTY: if (acc) begin
            main_q <= cap;
            state  <= ONE;
          end
          ONE: begin
            if (acc && !pop) begin
              skid_q   <= cap;
              state    <= TWO;
              in_ready <= 1'b0;
            end else if (acc && pop) begin
              main_q <= cap;
            end else if (pop) begin
              state <= EMPTY;
            end
          end
          TWO: if (pop) begin
            main_q   <= skid_r;
            state    <= ONE;
            in_ready <= 1'b1;
          end
          default: begin
            state    <= EMPTY;
            in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign out_pc       = main_q.pc;
  assign out_rs1_addr = main_q.rs1_addr;
  assign out_rs2_addr = main_q.rs2_addr;
  assign out_rs1_data = main_q.rs1_data;
  assign out_rs2_data = main_q.rs2_data;
  assign out_rd_addr  = main_q.rd_addr;
  assign out_imm      = main_q.imm;
  assign out_ctrl     = main_q.ctrl;

endmodule
